vec_reg_bank: RTL and testbench
===============================

VEC_REG_BANK -- requirements
Module: vec_reg_bank

Interface
REQ-001 Parameter NREGS, default 8, SHALL be the number of registers in each of the scalar and vector banks (power of two, at least 2).
REQ-002 Parameter SCALAR_W, default 21, SHALL be the scalar register width.
REQ-003 Parameter LANES, default 8, SHALL be the number of vector lanes.
REQ-004 Parameter ELEM_W, default 24, SHALL be the lane width; vector width VW = LANES*ELEM_W (192 at defaults).
REQ-005 clk  in  1  sole clock; all state updates on its rising edge.
REQ-006 rst  in  1  reset, asynchronous and active-high.
REQ-007 rd_en  in  1  read request for both ports.
REQ-008 ra1, ra2  in  AW=clog2(NREGS)  read addresses, ports 1 and 2.
REQ-009 ra1_vec, ra2_vec  in  1  per-port bank select: 0 scalar, 1 vector.
REQ-010 we  in  1  write enable.
REQ-011 wa  in  AW  write address.
REQ-012 w_vec  in  1  write bank select: 0 scalar, 1 vector.
REQ-013 w_splat  in  1  vector write takes wd_s broadcast into every lane.
REQ-014 w_mask  in  LANES  per-lane vector write enable.
REQ-015 wd_s  in  SCALAR_W  scalar write data.
REQ-016 wd_v  in  VW  vector write data; lane i is bits [i*ELEM_W +: ELEM_W].
REQ-017 clr_req  in  1  one-cycle request to zero both banks.
REQ-018 r1s, r2s  out  SCALAR_W  scalar read data.
REQ-019 r1v, r2v  out  VW  vector read data.
REQ-020 rd_valid  out  1  read data valid.
REQ-021 busy  out  1  clear sweep in progress.

Function
REQ-022 Storage SHALL be internal flip-flop/RAM arrays; no file I/O is permitted.
REQ-023 Reads SHALL have 1-cycle latency: when rd_en is sampled high, the port outputs and rd_valid=1 SHALL be registered on that edge.
REQ-024 A port SHALL update only its selected-bank output (r1s or r1v, r2s or r2v); the other bank's output SHALL hold.
REQ-025 With rd_en low, rd_valid SHALL go 0 next cycle and all data outputs SHALL hold.
REQ-026 A scalar write (we=1, w_vec=0) SHALL replace scalar[wa] with wd_s.
REQ-027 A vector write (we=1, w_vec=1) SHALL update only lanes with w_mask[i]=1; other lanes SHALL retain their value.
REQ-028 With w_splat=1, each masked lane SHALL receive wd_s zero-extended to ELEM_W if SCALAR_W<ELEM_W, or truncated to its low ELEM_W bits otherwise; wd_v is ignored.
REQ-029 A same-cycle read and write to the same bank and address SHALL return the post-write value, with masked lanes merged (write-first bypass).
REQ-030 The two read ports SHALL be independent; equal addresses SHALL return identical data.
REQ-031 FSM states: IDLE and CLEAR.
REQ-032 IDLE to CLEAR transition: on clr_req=1; the sweep index is set to 0.
REQ-033 In CLEAR, each cycle SHALL zero scalar[idx] and vector[idx], then increment idx.
REQ-034 After idx=NREGS-1 the FSM SHALL return to IDLE, so busy is high for exactly NREGS cycles.
REQ-035 busy SHALL be 1 exactly while in CLEAR.
REQ-036 While busy, we, rd_en and clr_req SHALL be ignored, and rd_valid SHALL be 0.
REQ-037 In IDLE, clr_req SHALL take priority over a same-cycle we (the write is dropped) and rd_en (no read occurs).

Reset
REQ-038 rst SHALL immediately force all registers of both banks, r1s, r2s, r1v, r2v, rd_valid, busy and idx to 0, and the FSM to IDLE.
REQ-039 rst asserted mid-sweep SHALL abort the sweep; operation SHALL resume in IDLE after deassertion.

Structure
REQ-040 Package vrf_pkg SHALL hold the state enum (IDLE, CLEAR) and a lane-extract helper.
REQ-041 Default parameter values SHALL be defined as constants in vrf_pkg.
REQ-042 A sub-module vrf_lane_merge SHALL combine the old vector, wd_v/splat data and w_mask; the same merge SHALL feed both the array write and the bypass path.

Verification
REQ-043 Write scalar[3]=0x1ABCD, then read ra1=3 scalar next cycle -> r1s=0x1ABCD, rd_valid=1 one cycle after rd_en.
REQ-044 Write vector[2]=all lanes 0xFFFFFF, then write with w_mask=0x05, wd_v lanes 0x000011 -> lanes 0 and 2 read 0x000011, other lanes 0xFFFFFF.
REQ-045 Splat wd_s=0x0000AB to vector[5] with w_mask=0xFF -> every lane of r2v reads 0x0000AB.
REQ-046 Same-cycle write scalar[1]=0x00042 and read ra1=1, ra2=1 scalar -> r1s=r2s=0x00042 next cycle.
REQ-047 Pulse clr_req after filling all registers -> busy high exactly 8 cycles; a we during busy is dropped; all reads afterwards return 0.
REQ-048 Assert rst at sweep idx=4, then deassert -> all registers 0, busy=0, FSM IDLE; a normal write/read then succeeds.

Source files
------------

// File: rtl/vrf_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : vrf_pkg
//  Description : Shared definitions for the vector register bank: default
//                geometry constants, the clear-sweep state encoding and a
//                lane bit-offset helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package vrf_pkg;

    // Default geometry of the register bank.
    localparam int C_NREGS_DEF    = 8;
    localparam int C_SCALAR_W_DEF = 21;
    localparam int C_LANES_DEF    = 8;
    localparam int C_ELEM_W_DEF   = 24;

    // Clear-sweep controller states.
    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } vrf_state_t;

    // Bit offset of a lane inside a packed vector word.
    function automatic int lane_lsb(input int lane, input int elem_w);
        return lane * elem_w;
    endfunction

endpackage : vrf_pkg
`default_nettype wire

// File: rtl/vrf_lane_merge.sv
`default_nettype none
// ============================================================================
//  Module      : vrf_lane_merge
//  Description : Builds the post-write value of a vector register. Each lane
//                takes either its slice of wd_v or the broadcast scalar
//                (splat), but only where mask is set; other lanes keep old_vec.
//  Ports       : old_vec  - current register contents
//                wd_v     - per-lane write data
//                wd_s     - scalar data used for splat
//                splat    - broadcast wd_s instead of wd_v
//                mask     - per-lane write enable
//                new_vec  - merged result
//  Revision    : 1.0 - initial release
// ============================================================================
module vrf_lane_merge
    import vrf_pkg::*;
#(
    parameter int LANES    = C_LANES_DEF,
    parameter int ELEM_W   = C_ELEM_W_DEF,
    parameter int SCALAR_W = C_SCALAR_W_DEF
) (
    input  logic [LANES*ELEM_W-1:0] old_vec,
    input  logic [LANES*ELEM_W-1:0] wd_v,
    input  logic [SCALAR_W-1:0]     wd_s,
    input  logic                    splat,
    input  logic [LANES-1:0]        mask,
    output logic [LANES*ELEM_W-1:0] new_vec
);

    logic [ELEM_W-1:0] w_splat_elem;

    // Fit the scalar into one lane: zero-extend when narrower, keep the low
    // bits otherwise.
    generate
        if (SCALAR_W < ELEM_W) begin : g_zext
            assign w_splat_elem = {{(ELEM_W - SCALAR_W){1'b0}}, wd_s};
        end else begin : g_trunc
            assign w_splat_elem = wd_s[ELEM_W-1:0];
        end
    endgenerate

    generate
        for (genvar i = 0; i < LANES; i++) begin : g_lane
            logic [ELEM_W-1:0] w_src;
            assign w_src = splat ? w_splat_elem
                                 : wd_v[lane_lsb(i, ELEM_W) +: ELEM_W];
            assign new_vec[lane_lsb(i, ELEM_W) +: ELEM_W] =
                mask[i] ? w_src : old_vec[lane_lsb(i, ELEM_W) +: ELEM_W];
        end
    endgenerate

endmodule : vrf_lane_merge
`default_nettype wire

// File: rtl/vec_reg_bank.sv
`default_nettype none
// ============================================================================
//  Module      : vec_reg_bank
//  Description : Scalar + vector register bank with two registered read
//                ports, one write port (masked / splat vector writes),
//                write-first bypass and a one-register-per-cycle clear sweep.
//  Ports       : clk, rst            - clock, async active-high reset
//                rd_en, ra1/ra2,
//                ra1_vec/ra2_vec     - read request, addresses, bank selects
//                we, wa, w_vec,
//                w_splat, w_mask,
//                wd_s, wd_v          - write port
//                clr_req             - start a clear sweep of both banks
//                r1s/r2s, r1v/r2v    - registered read data
//                rd_valid            - read data valid
//                busy                - clear sweep in progress
//  Revision    : 1.0 - initial release
// ============================================================================
module vec_reg_bank
    import vrf_pkg::*;
#(
    parameter int NREGS    = C_NREGS_DEF,
    parameter int SCALAR_W = C_SCALAR_W_DEF,
    parameter int LANES    = C_LANES_DEF,
    parameter int ELEM_W   = C_ELEM_W_DEF
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      rd_en,
    input  logic [$clog2(NREGS)-1:0]  ra1,
    input  logic [$clog2(NREGS)-1:0]  ra2,
    input  logic                      ra1_vec,
    input  logic                      ra2_vec,
    input  logic                      we,
    input  logic [$clog2(NREGS)-1:0]  wa,
    input  logic                      w_vec,
    input  logic                      w_splat,
    input  logic [LANES-1:0]          w_mask,
    input  logic [SCALAR_W-1:0]       wd_s,
    input  logic [LANES*ELEM_W-1:0]   wd_v,
    input  logic                      clr_req,
    output logic [SCALAR_W-1:0]       r1s,
    output logic [SCALAR_W-1:0]       r2s,
    output logic [LANES*ELEM_W-1:0]   r1v,
    output logic [LANES*ELEM_W-1:0]   r2v,
    output logic                      rd_valid,
    output logic                      busy
);

    localparam int              AW     = $clog2(NREGS);
    localparam int              VW     = LANES * ELEM_W;
    localparam logic [AW-1:0]   C_LAST = AW'(NREGS - 1);

    logic [SCALAR_W-1:0] r_smem [NREGS];
    logic [VW-1:0]       r_vmem [NREGS];

    vrf_state_t          r_state;
    logic [AW-1:0]       r_idx;

    logic                w_we;
    logic                w_rd;
    logic [VW-1:0]       w_vec_new;
    logic [SCALAR_W-1:0] w_r1s;
    logic [SCALAR_W-1:0] w_r2s;
    logic [VW-1:0]       w_r1v;
    logic [VW-1:0]       w_r2v;

    // A clear request in IDLE wins over any same-cycle write or read; in
    // CLEAR the user ports are ignored entirely.
    always_comb begin
        w_we = (r_state == IDLE) && we    && !clr_req;
        w_rd = (r_state == IDLE) && rd_en && !clr_req;
    end

    // One merge result serves both the array write and the read bypass, so a
    // bypassed read always matches what lands in the array.
    vrf_lane_merge #(
        .LANES    (LANES),
        .ELEM_W   (ELEM_W),
        .SCALAR_W (SCALAR_W)
    ) u_merge (
        .old_vec (r_vmem[wa]),
        .wd_v    (wd_v),
        .wd_s    (wd_s),
        .splat   (w_splat),
        .mask    (w_mask),
        .new_vec (w_vec_new)
    );

    // Write-first bypass on each read port.
    always_comb begin
        w_r1s = r_smem[ra1];
        w_r2s = r_smem[ra2];
        w_r1v = r_vmem[ra1];
        w_r2v = r_vmem[ra2];
        if (w_we && !w_vec && (wa == ra1)) w_r1s = wd_s;
        if (w_we && !w_vec && (wa == ra2)) w_r2s = wd_s;
        if (w_we &&  w_vec && (wa == ra1)) w_r1v = w_vec_new;
        if (w_we &&  w_vec && (wa == ra2)) w_r2v = w_vec_new;
    end

    // Clear-sweep controller.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_idx   <= '0;
            busy    <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (clr_req) begin
                        r_state <= CLEAR;
                        r_idx   <= '0;
                        busy    <= 1'b1;
                    end
                end
                CLEAR: begin
                    r_idx <= r_idx + 1'b1;
                    if (r_idx == C_LAST) begin
                        r_state <= IDLE;
                        busy    <= 1'b0;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

    // Register arrays.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) begin
                r_smem[i] <= '0;
                r_vmem[i] <= '0;
            end
        end else if (r_state == CLEAR) begin
            r_smem[r_idx] <= '0;
            r_vmem[r_idx] <= '0;
        end else if (w_we) begin
            if (w_vec) r_vmem[wa] <= w_vec_new;
            else       r_smem[wa] <= wd_s;
        end
    end

    // Read ports: only the selected bank's output of each port is refreshed.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r1s      <= '0;
            r2s      <= '0;
            r1v      <= '0;
            r2v      <= '0;
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= w_rd;
            if (w_rd) begin
                if (ra1_vec) r1v <= w_r1v;
                else         r1s <= w_r1s;
                if (ra2_vec) r2v <= w_r2v;
                else         r2s <= w_r2s;
            end
        end
    end

endmodule : vec_reg_bank
`default_nettype wire

// File: tb/tb_vec_reg_bank.sv
`default_nettype none
// ============================================================================
//  Module      : tb_vec_reg_bank
//  Description : Directed table-driven bench for vec_reg_bank plus hand
//                sequences for the clear sweep and reset during a sweep.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_vec_reg_bank;

    logic         clk = 1'b0;
    logic         rst;
    logic         rd_en;
    logic [2:0]   ra1, ra2;
    logic         ra1_vec, ra2_vec;
    logic         we;
    logic [2:0]   wa;
    logic         w_vec, w_splat;
    logic [7:0]   w_mask;
    logic [20:0]  wd_s;
    logic [191:0] wd_v;
    logic         clr_req;
    logic [20:0]  r1s, r2s;
    logic [191:0] r1v, r2v;
    logic         rd_valid, busy;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    vec_reg_bank #(
        .NREGS(8), .SCALAR_W(21), .LANES(8), .ELEM_W(24)
    ) dut (
        .clk(clk), .rst(rst), .rd_en(rd_en), .ra1(ra1), .ra2(ra2),
        .ra1_vec(ra1_vec), .ra2_vec(ra2_vec), .we(we), .wa(wa),
        .w_vec(w_vec), .w_splat(w_splat), .w_mask(w_mask), .wd_s(wd_s),
        .wd_v(wd_v), .clr_req(clr_req), .r1s(r1s), .r2s(r2s), .r1v(r1v),
        .r2v(r2v), .rd_valid(rd_valid), .busy(busy)
    );

    typedef struct {
        logic         rd_en;
        logic [2:0]   ra1;
        logic         ra1_vec;
        logic [2:0]   ra2;
        logic         ra2_vec;
        logic         we;
        logic [2:0]   wa;
        logic         w_vec;
        logic         w_splat;
        logic [7:0]   w_mask;
        logic [20:0]  wd_s;
        logic [191:0] wd_v;
        logic [20:0]  e_r1s;
        logic [20:0]  e_r2s;
        logic [191:0] e_r1v;
        logic [191:0] e_r2v;
        logic         e_valid;
    } vec_t;

    function automatic logic [191:0] fill(input logic [23:0] e);
        logic [191:0] v;
        for (int i = 0; i < 8; i++) v[i*24 +: 24] = e;
        return v;
    endfunction

    function automatic vec_t mk(
        input logic rd, input logic [2:0] a1, input logic a1v,
        input logic [2:0] a2, input logic a2v,
        input logic w, input logic [2:0] a, input logic wv, input logic sp,
        input logic [7:0] m, input logic [20:0] ds, input logic [191:0] dv,
        input logic [20:0] e1s, input logic [20:0] e2s,
        input logic [191:0] e1v, input logic [191:0] e2v, input logic ev);
        vec_t t;
        t.rd_en = rd; t.ra1 = a1; t.ra1_vec = a1v; t.ra2 = a2; t.ra2_vec = a2v;
        t.we = w; t.wa = a; t.w_vec = wv; t.w_splat = sp; t.w_mask = m;
        t.wd_s = ds; t.wd_v = dv;
        t.e_r1s = e1s; t.e_r2s = e2s; t.e_r1v = e1v; t.e_r2v = e2v;
        t.e_valid = ev;
        return t;
    endfunction

    task automatic chk(input string name, input logic [191:0] act,
                       input logic [191:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        rd_en = 0; ra1 = 0; ra2 = 0; ra1_vec = 0; ra2_vec = 0;
        we = 0; wa = 0; w_vec = 0; w_splat = 0; w_mask = 0;
        wd_s = 0; wd_v = 0; clr_req = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_s(input logic [2:0] a, input logic [20:0] d);
        idle_inputs(); we = 1; wa = a; wd_s = d;
        tick();
    endtask

    task automatic write_v(input logic [2:0] a, input logic [191:0] d);
        idle_inputs(); we = 1; wa = a; w_vec = 1; w_mask = 8'hFF; wd_v = d;
        tick();
    endtask

    vec_t         tbl [11];
    logic [191:0] z;
    logic [191:0] m2;
    logic [191:0] l7;
    int           cnt;

    initial begin
        z  = '0;
        m2 = fill(24'hFFFFFF);
        m2[0 +: 24]  = 24'h000011;
        m2[48 +: 24] = 24'h000011;
        l7 = '0;
        l7[168 +: 24] = 24'h1FFFFF;

        //           rd a1 v1 a2 v2  we wa wv sp mask   wd_s        wd_v
        //           e_r1s       e_r2s       e_r1v e_r2v valid
        tbl[0]  = mk(0, 0,0, 0,0,   1, 3,0,0, 8'h00, 21'h1ABCD, z,
                     21'h0,      21'h0,      z,  z,  0);
        tbl[1]  = mk(1, 3,0, 0,0,   0, 0,0,0, 8'h00, 21'h0,     z,
                     21'h1ABCD,  21'h0,      z,  z,  1);
        tbl[2]  = mk(0, 0,0, 0,0,   1, 2,1,0, 8'hFF, 21'h0,     fill(24'hFFFFFF),
                     21'h1ABCD,  21'h0,      z,  z,  0);
        tbl[3]  = mk(1, 2,1, 3,0,   1, 2,1,0, 8'h05, 21'h0,     fill(24'h000011),
                     21'h1ABCD,  21'h1ABCD,  m2, z,  1);
        tbl[4]  = mk(1, 2,1, 2,1,   0, 0,0,0, 8'h00, 21'h0,     z,
                     21'h1ABCD,  21'h1ABCD,  m2, m2, 1);
        tbl[5]  = mk(0, 0,0, 0,0,   1, 5,1,1, 8'hFF, 21'h0000AB, fill(24'h123456),
                     21'h1ABCD,  21'h1ABCD,  m2, m2, 0);
        tbl[6]  = mk(1, 3,0, 5,1,   0, 0,0,0, 8'h00, 21'h0,     z,
                     21'h1ABCD,  21'h1ABCD,  m2, fill(24'h0000AB), 1);
        tbl[7]  = mk(1, 1,0, 1,0,   1, 1,0,0, 8'h00, 21'h00042, z,
                     21'h00042,  21'h00042,  m2, fill(24'h0000AB), 1);
        tbl[8]  = mk(1, 6,1, 6,0,   1, 6,1,1, 8'h80, 21'h1FFFFF, fill(24'hABCDEF),
                     21'h00042,  21'h0,      l7, fill(24'h0000AB), 1);
        tbl[9]  = mk(0, 0,0, 0,0,   1, 1,0,0, 8'h00, 21'h00007, z,
                     21'h00042,  21'h0,      l7, fill(24'h0000AB), 0);
        tbl[10] = mk(1, 1,0, 2,1,   1, 2,1,0, 8'h00, 21'h0,     z,
                     21'h00007,  21'h0,      l7, m2, 1);

        // Reset state
        idle_inputs();
        rst = 1;
        repeat (2) @(posedge clk);
        #1;
        chk("reset r1s", 192'(r1s), 192'(0));
        chk("reset r2s", 192'(r2s), 192'(0));
        chk("reset r1v", r1v, z);
        chk("reset r2v", r2v, z);
        chk("reset rd_valid", 192'(rd_valid), 192'(0));
        chk("reset busy", 192'(busy), 192'(0));
        rst = 0;
        tick();

        // Table vectors: apply for one edge, then compare all outputs
        for (int i = 0; i < 11; i++) begin
            rd_en = tbl[i].rd_en; ra1 = tbl[i].ra1; ra1_vec = tbl[i].ra1_vec;
            ra2 = tbl[i].ra2; ra2_vec = tbl[i].ra2_vec;
            we = tbl[i].we; wa = tbl[i].wa; w_vec = tbl[i].w_vec;
            w_splat = tbl[i].w_splat; w_mask = tbl[i].w_mask;
            wd_s = tbl[i].wd_s; wd_v = tbl[i].wd_v; clr_req = 0;
            tick();
            chk($sformatf("vec%0d r1s", i), 192'(r1s), 192'(tbl[i].e_r1s));
            chk($sformatf("vec%0d r2s", i), 192'(r2s), 192'(tbl[i].e_r2s));
            chk($sformatf("vec%0d r1v", i), r1v, tbl[i].e_r1v);
            chk($sformatf("vec%0d r2v", i), r2v, tbl[i].e_r2v);
            chk($sformatf("vec%0d rd_valid", i), 192'(rd_valid), 192'(tbl[i].e_valid));
        end

        // Clear sweep: fill every register, then clear
        for (int i = 0; i < 8; i++) begin
            write_s(3'(i), 21'(i + 1));
            write_v(3'(i), fill(24'(i + 16)));
        end
        idle_inputs();
        clr_req = 1; we = 1; wa = 0; wd_s = 21'h77; rd_en = 1;
        tick();
        chk("clr start busy", 192'(busy), 192'(1));
        chk("clr start rd_valid", 192'(rd_valid), 192'(0));
        // Writes, reads and clear requests while busy must all be ignored
        we = 1; wa = 0; w_vec = 0; wd_s = 21'h99; rd_en = 1; clr_req = 1;
        cnt = 0;
        while (busy && cnt < 20) begin
            cnt++;
            chk("clr rd_valid while busy", 192'(rd_valid), 192'(0));
            tick();
        end
        chk("clr busy cycles", 192'(cnt), 192'(8));
        idle_inputs();
        for (int i = 0; i < 8; i++) begin
            idle_inputs(); rd_en = 1; ra1 = 3'(i); ra2 = 3'(i); ra2_vec = 1;
            tick();
            chk($sformatf("post-clr scalar[%0d]", i), 192'(r1s), 192'(0));
            chk($sformatf("post-clr vector[%0d]", i), r2v, z);
            chk($sformatf("post-clr rd_valid %0d", i), 192'(rd_valid), 192'(1));
        end
        idle_inputs();
        tick();
        chk("idle after clr busy", 192'(busy), 192'(0));

        // Reset in the middle of a sweep
        write_s(3'd6, 21'h00321);
        write_v(3'd7, fill(24'h000007));
        write_v(3'd4, fill(24'h000005));
        idle_inputs(); rd_en = 1; ra1 = 3'd6;
        tick();
        chk("pre-abort scalar[6]", 192'(r1s), 192'(21'h00321));
        idle_inputs(); clr_req = 1;
        tick();
        idle_inputs();
        repeat (4) tick();
        chk("abort busy before rst", 192'(busy), 192'(1));
        #2 rst = 1;
        #1;
        chk("abort busy", 192'(busy), 192'(0));
        chk("abort rd_valid", 192'(rd_valid), 192'(0));
        chk("abort r1s", 192'(r1s), 192'(0));
        @(posedge clk);
        #1 rst = 0;
        repeat (2) tick();
        chk("abort stays idle", 192'(busy), 192'(0));
        idle_inputs(); rd_en = 1; ra1 = 3'd6; ra2 = 3'd7; ra2_vec = 1;
        tick();
        chk("abort scalar[6]", 192'(r1s), 192'(0));
        chk("abort vector[7]", r2v, z);
        write_s(3'd4, 21'h0BEEF);
        idle_inputs(); rd_en = 1; ra1 = 3'd4; ra2 = 3'd4; ra2_vec = 1;
        tick();
        chk("post-abort scalar[4]", 192'(r1s), 192'(21'h0BEEF));
        chk("post-abort vector[4]", r2v, z);
        chk("post-abort rd_valid", 192'(rd_valid), 192'(1));
        write_v(3'd3, fill(24'h00003C));
        idle_inputs(); rd_en = 1; ra2 = 3'd3; ra2_vec = 1;
        tick();
        chk("post-abort vector[3]", r2v, fill(24'h00003C));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_vec_reg_bank
`default_nettype wire
